xge_status_sync: RTL and testbench

- Carries MAC status events and fault levels from the XGMII RX and TX clock domains into the Wishbone clock domain.
- Output ports connect directly to the status_* inputs of the Wishbone register/interrupt block.
- Each pulse uses a per-bit req/ack toggle handshake, so no event is lost. Events that arrive while a transfer is in flight are coalesced, never dropped entirely.
- Fault levels use plain multi-flop synchronizers.

---
 rtl/xge_status_pkg.sv | 23 ++
 rtl/xge_pulse_sync.sv | 84 ++++++++
 rtl/xge_status_sync.sv | 94 +++++++++
 tb/tb_xge_status_sync.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xge_status_pkg.sv
// Shared constants for the MAC status clock-domain crossing: status bit
// positions (same order as the interrupt sources) and the source FSM states.
`timescale 1ns/1ps
package xge_status_pkg;

    localparam int STAT_FRAGMENT = 8;
    localparam int STAT_CRC      = 7;
    localparam int STAT_PAUSE    = 6;
    localparam int STAT_REMOTE   = 5;
    localparam int STAT_LOCAL    = 4;
    localparam int STAT_RXUDF    = 3;
    localparam int STAT_RXOVF    = 2;
    localparam int STAT_TXUDF    = 1;
    localparam int STAT_TXOVF    = 0;
    localparam int STAT_W        = 9;

    typedef enum logic [1:0] {
        SRC_IDLE      = 2'd0,
        SRC_BUSY      = 2'd1,
        SRC_BUSY_PEND = 2'd2
    } src_state_e;

endpackage

// File: rtl/xge_pulse_sync.sv
// One status event carried across clock domains with a req/ack toggle
// handshake; events arriving while a transfer is in flight coalesce into one.
`timescale 1ns/1ps
module xge_pulse_sync
    import xge_status_pkg::*;
#(
    parameter int SYNC_STAGES = 2   // legal 2..4
) (
    input  logic src_clk,
    input  logic src_rst_n,
    input  logic src_pulse,
    input  logic dst_clk,
    input  logic dst_rst,
    output logic dst_pulse
);

    src_state_e state;
    logic       req;
    logic       edge_q;
    logic       ack_done;

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] ack_sync;
    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] req_sync;

    assign ack_done = (ack_sync[SYNC_STAGES-1] == req);

    always_ff @(posedge src_clk or negedge src_rst_n) begin
        if (!src_rst_n) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], edge_q};
        end
    end

    // A pulse landing on the same cycle the ack returns starts the next
    // transfer immediately, so it is never lost.
    always_ff @(posedge src_clk or negedge src_rst_n) begin
        if (!src_rst_n) begin
            state <= SRC_IDLE;
            req   <= 1'b0;
        end else begin
            case (state)
                SRC_IDLE: begin
                    if (src_pulse) begin
                        req   <= ~req;
                        state <= SRC_BUSY;
                    end
                end
                SRC_BUSY: begin
                    if (ack_done) begin
                        if (src_pulse) begin
                            req <= ~req;
                        end else begin
                            state <= SRC_IDLE;
                        end
                    end else if (src_pulse) begin
                        state <= SRC_BUSY_PEND;
                    end
                end
                SRC_BUSY_PEND: begin
                    if (ack_done) begin
                        req   <= ~req;
                        state <= SRC_BUSY;
                    end
                end
                default: state <= SRC_IDLE;
            endcase
        end
    end

    always_ff @(posedge dst_clk or posedge dst_rst) begin
        if (dst_rst) begin
            req_sync <= '0;
            edge_q   <= 1'b0;
        end else begin
            req_sync <= {req_sync[SYNC_STAGES-2:0], req};
            edge_q   <= req_sync[SYNC_STAGES-1];
        end
    end

    // edge_q doubles as the ack, so the pulse lasts exactly one dst cycle.
    assign dst_pulse = req_sync[SYNC_STAGES-1] ^ edge_q;

endmodule

// File: rtl/xge_status_sync.sv
// Brings RX/TX-domain MAC status events and fault levels into the Wishbone
// clock domain for the register/interrupt block.
`timescale 1ns/1ps
module xge_status_sync
    import xge_status_pkg::*;
#(
    parameter int SYNC_STAGES = 2   // legal 2..4
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic clk_xgmii_rx,
    input  logic reset_xgmii_rx_n,
    input  logic clk_xgmii_tx,
    input  logic reset_xgmii_tx_n,
    input  logic rx_crc_error,
    input  logic rx_fragment_error,
    input  logic rx_pause_frame,
    input  logic rx_rxdfifo_ovflow,
    input  logic rx_local_fault,
    input  logic rx_remote_fault,
    input  logic tx_txdfifo_ovflow,
    input  logic tx_txdfifo_udflow,
    input  logic tx_rxdfifo_udflow,
    output logic status_crc_error,
    output logic status_fragment_error,
    output logic status_pause_frame_rx,
    output logic status_rxdfifo_ovflow,
    output logic status_txdfifo_ovflow,
    output logic status_txdfifo_udflow,
    output logic status_rxdfifo_udflow,
    output logic status_local_fault,
    output logic status_remote_fault
);

    localparam int RX_IDX [4] = '{STAT_CRC, STAT_FRAGMENT, STAT_PAUSE, STAT_RXOVF};
    localparam int TX_IDX [3] = '{STAT_TXOVF, STAT_TXUDF, STAT_RXUDF};

    logic [STAT_W-1:0] status_vec;
    logic [3:0]        rx_pulses;
    logic [2:0]        tx_pulses;

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] local_fault_sync;
    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] remote_fault_sync;

    assign rx_pulses = {rx_rxdfifo_ovflow, rx_pause_frame, rx_fragment_error, rx_crc_error};
    assign tx_pulses = {tx_rxdfifo_udflow, tx_txdfifo_udflow, tx_txdfifo_ovflow};

    for (genvar i = 0; i < 4; i++) begin : g_rx
        xge_pulse_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .src_clk   (clk_xgmii_rx),
            .src_rst_n (reset_xgmii_rx_n),
            .src_pulse (rx_pulses[i]),
            .dst_clk   (wb_clk_i),
            .dst_rst   (wb_rst_i),
            .dst_pulse (status_vec[RX_IDX[i]])
        );
    end

    for (genvar i = 0; i < 3; i++) begin : g_tx
        xge_pulse_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .src_clk   (clk_xgmii_tx),
            .src_rst_n (reset_xgmii_tx_n),
            .src_pulse (tx_pulses[i]),
            .dst_clk   (wb_clk_i),
            .dst_rst   (wb_rst_i),
            .dst_pulse (status_vec[TX_IDX[i]])
        );
    end

    // Fault levels change slowly; a plain synchronizer is enough.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            local_fault_sync  <= '0;
            remote_fault_sync <= '0;
        end else begin
            local_fault_sync  <= {local_fault_sync[SYNC_STAGES-2:0], rx_local_fault};
            remote_fault_sync <= {remote_fault_sync[SYNC_STAGES-2:0], rx_remote_fault};
        end
    end

    assign status_vec[STAT_LOCAL]  = local_fault_sync[SYNC_STAGES-1];
    assign status_vec[STAT_REMOTE] = remote_fault_sync[SYNC_STAGES-1];

    assign status_crc_error      = status_vec[STAT_CRC];
    assign status_fragment_error = status_vec[STAT_FRAGMENT];
    assign status_pause_frame_rx = status_vec[STAT_PAUSE];
    assign status_rxdfifo_ovflow = status_vec[STAT_RXOVF];
    assign status_txdfifo_ovflow = status_vec[STAT_TXOVF];
    assign status_txdfifo_udflow = status_vec[STAT_TXUDF];
    assign status_rxdfifo_udflow = status_vec[STAT_RXUDF];
    assign status_local_fault    = status_vec[STAT_LOCAL];
    assign status_remote_fault   = status_vec[STAT_REMOTE];

endmodule

// File: tb/tb_xge_status_sync.sv
// Directed and randomized bench for xge_status_sync with an event-level
// scoreboard: every source event must be followed by a delivered pulse.
`timescale 1ns/1ps
module tb_xge_status_sync;

    localparam int    SYNC_STAGES = 2;
    localparam real   LATE_NS     = 400.0;
    localparam int    MAXEV       = 4096;

    logic wb_clk_i = 1'b0;
    logic wb_rst_i = 1'b1;
    logic clk_xgmii_rx = 1'b0;
    logic clk_xgmii_tx = 1'b0;
    logic reset_xgmii_rx_n = 1'b0;
    logic reset_xgmii_tx_n = 1'b0;
    logic [3:0] rx_in = '0;     // 0 crc, 1 fragment, 2 pause, 3 rxovf
    logic [2:0] tx_in = '0;     // 0 txovf, 1 txudf, 2 rxudf
    logic rx_lf = 1'b0;
    logic rx_rf = 1'b0;

    logic status_crc_error, status_fragment_error, status_pause_frame_rx;
    logic status_rxdfifo_ovflow, status_txdfifo_ovflow, status_txdfifo_udflow;
    logic status_rxdfifo_udflow, status_local_fault, status_remote_fault;
    logic [6:0] so;

    assign so = {status_rxdfifo_udflow, status_txdfifo_udflow, status_txdfifo_ovflow,
                 status_rxdfifo_ovflow, status_pause_frame_rx, status_fragment_error,
                 status_crc_error};

    real wb_half = 3.2;
    always #(wb_half) wb_clk_i = ~wb_clk_i;
    initial begin #1.1; forever #3.2 clk_xgmii_rx = ~clk_xgmii_rx; end
    initial begin #2.3; forever #3.2 clk_xgmii_tx = ~clk_xgmii_tx; end

    xge_status_sync #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .wb_clk_i              (wb_clk_i),
        .wb_rst_i              (wb_rst_i),
        .clk_xgmii_rx          (clk_xgmii_rx),
        .reset_xgmii_rx_n      (reset_xgmii_rx_n),
        .clk_xgmii_tx          (clk_xgmii_tx),
        .reset_xgmii_tx_n      (reset_xgmii_tx_n),
        .rx_crc_error          (rx_in[0]),
        .rx_fragment_error     (rx_in[1]),
        .rx_pause_frame        (rx_in[2]),
        .rx_rxdfifo_ovflow     (rx_in[3]),
        .rx_local_fault        (rx_lf),
        .rx_remote_fault       (rx_rf),
        .tx_txdfifo_ovflow     (tx_in[0]),
        .tx_txdfifo_udflow     (tx_in[1]),
        .tx_rxdfifo_udflow     (tx_in[2]),
        .status_crc_error      (status_crc_error),
        .status_fragment_error (status_fragment_error),
        .status_pause_frame_rx (status_pause_frame_rx),
        .status_rxdfifo_ovflow (status_rxdfifo_ovflow),
        .status_txdfifo_ovflow (status_txdfifo_ovflow),
        .status_txdfifo_udflow (status_txdfifo_udflow),
        .status_rxdfifo_udflow (status_rxdfifo_udflow),
        .status_local_fault    (status_local_fault),
        .status_remote_fault   (status_remote_fault)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Pulse monitor and scoreboard state (each written by one process only)
    int      out_cnt [7] = '{default: 0};
    int      wide_cnt    = 0;
    int      wb_cyc      = 0;
    logic [6:0] so_prev  = '0;
    bit      model_en    = 1'b0;
    realtime in_t [4][MAXEV];
    int      in_cnt   [4] = '{default: 0};
    int      served   [4] = '{default: 0};
    int      late_cnt [4] = '{default: 0};
    int      last_out [4] = '{default: -1};
    int      min_gap  [4] = '{default: 1000000};

    initial begin
        forever begin
            @(posedge clk_xgmii_rx);
            if (model_en) begin
                for (int b = 0; b < 4; b++) begin
                    if (rx_in[b] && in_cnt[b] < MAXEV) begin
                        in_t[b][in_cnt[b]] = $realtime;
                        in_cnt[b] = in_cnt[b] + 1;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge wb_clk_i);
            wb_cyc = wb_cyc + 1;
            for (int b = 0; b < 7; b++) begin
                if (so[b]) begin
                    out_cnt[b] = out_cnt[b] + 1;
                    if (so_prev[b]) wide_cnt = wide_cnt + 1;
                    if (b < 4 && model_en) begin
                        if (last_out[b] >= 0 && wb_cyc - last_out[b] < min_gap[b])
                            min_gap[b] = wb_cyc - last_out[b];
                        last_out[b] = wb_cyc;
                        while (served[b] < in_cnt[b] && in_t[b][served[b]] < $realtime)
                            served[b] = served[b] + 1;
                    end
                end
                if (b < 4 && model_en && served[b] < in_cnt[b] &&
                    ($realtime - in_t[b][served[b]]) > LATE_NS) begin
                    late_cnt[b] = late_cnt[b] + 1;
                    served[b]   = served[b] + 1;
                end
            end
            so_prev = so;
        end
    end

    task automatic chk_eq(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
        n_checks++;
        assert (obs >= lo && obs <= hi) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    endtask

    task automatic wb_cycles(input int n);
        repeat (n) @(posedge wb_clk_i);
        #1;
    endtask

    task automatic rx_tick(input int n);
        repeat (n) @(posedge clk_xgmii_rx);
        #0.5;
    endtask

    task automatic rx_pulse(input int b);
        @(posedge clk_xgmii_rx); #0.5; rx_in[b] = 1'b1;
        @(posedge clk_xgmii_rx); #0.5; rx_in[b] = 1'b0;
    endtask

    task automatic tx_pulse(input int b, input int len);
        @(posedge clk_xgmii_tx); #0.5; tx_in[b] = 1'b1;
        repeat (len) @(posedge clk_xgmii_tx);
        #0.5; tx_in[b] = 1'b0;
    endtask

    // wb cycles until output bit b is seen high; -1 if the budget expires
    task automatic wait_pulse(input int b, input int max_cyc, output int n);
        n = -1;
        for (int i = 1; i <= max_cyc; i++) begin
            @(posedge wb_clk_i); #1;
            if (so[b]) begin n = i; break; end
        end
    endtask

    task automatic wait_level(input bit want_local, input logic val, input int max_cyc, output int n);
        n = -1;
        for (int i = 1; i <= max_cyc; i++) begin
            @(posedge wb_clk_i); #1;
            if ((want_local ? status_local_fault : status_remote_fault) === val) begin n = i; break; end
        end
    endtask

    function automatic int others_delta(input int snap [7], input int skip);
        int s = 0;
        for (int b = 0; b < 7; b++) if (b != skip) s += out_cnt[b] - snap[b];
        return s;
    endfunction

    int snap [7];
    int snap2 [7];
    int n;
    int ref_in;

    initial begin
        // Reset state
        wb_cycles(4);
        chk_eq("reset_pulses_zero", int'(so), 0);
        chk_eq("reset_levels_zero", int'({status_local_fault, status_remote_fault}), 0);
        @(negedge wb_clk_i); wb_rst_i = 1'b0;
        reset_xgmii_rx_n = 1'b1;
        reset_xgmii_tx_n = 1'b1;
        wb_cycles(10);

        // Isolated crc pulse, both sides at 156.25 MHz
        snap = out_cnt;
        @(posedge clk_xgmii_rx); #0.5; rx_in[0] = 1'b1;
        @(posedge clk_xgmii_rx); #0.5; rx_in[0] = 1'b0;
        wait_pulse(0, 20, n);
        chk_range("iso_latency", n, SYNC_STAGES, SYNC_STAGES + 2);
        @(posedge wb_clk_i); #1;
        chk_eq("iso_width", int'(so[0]), 0);
        wb_cycles(30);
        chk_eq("iso_count", out_cnt[0] - snap[0], 1);
        chk_eq("iso_others_quiet", others_delta(snap, 0), 0);

        // Burst of 5 on txdfifo_udflow coalesces into two pulses
        snap = out_cnt;
        tx_pulse(1, 5);
        wb_cycles(60);
        chk_eq("burst_count", out_cnt[5] - snap[5], 2);
        chk_eq("burst_others_quiet", others_delta(snap, 5), 0);
        snap = out_cnt;
        tx_pulse(1, 1);
        wb_cycles(40);
        chk_eq("burst_then_idle", out_cnt[5] - snap[5], 1);

        // Ten pause events spaced 12 rx cycles apart all get through
        snap = out_cnt;
        for (int i = 0; i < 10; i++) begin
            rx_pulse(2);
            rx_tick(10);
        end
        wb_cycles(40);
        chk_eq("spaced_count", out_cnt[2] - snap[2], 10);

        // Fault levels
        @(posedge clk_xgmii_rx); #0.5; rx_lf = 1'b1;
        wait_level(1'b1, 1'b1, 20, n);
        chk_range("local_rise", n, SYNC_STAGES, SYNC_STAGES + 1);
        @(posedge clk_xgmii_rx); #0.5; rx_lf = 1'b0;
        wait_level(1'b1, 1'b0, 20, n);
        chk_range("local_fall", n, SYNC_STAGES, SYNC_STAGES + 1);
        @(posedge clk_xgmii_rx); #0.5; rx_rf = 1'b1;
        wait_level(1'b0, 1'b1, 20, n);
        chk_range("remote_rise", n, SYNC_STAGES, SYNC_STAGES + 1);
        chk_eq("remote_local_indep", int'(status_local_fault), 0);
        @(posedge clk_xgmii_rx); #0.5; rx_rf = 1'b0;
        wb_cycles(10);

        // WB reset while a crc transfer is in flight
        rx_lf = 1'b1;
        wb_cycles(6);
        snap = out_cnt;
        @(posedge clk_xgmii_rx); #0.5; rx_in[0] = 1'b1;
        @(posedge clk_xgmii_rx); #0.5; rx_in[0] = 1'b0;
        @(posedge wb_clk_i); #1; wb_rst_i = 1'b1;
        wb_cycles(3);
        chk_eq("wbrst_pulses_zero", int'(so), 0);
        chk_eq("wbrst_level_zero", int'(status_local_fault), 0);
        @(negedge wb_clk_i); wb_rst_i = 1'b0;
        wb_cycles(2 * SYNC_STAGES + 2);
        snap2 = out_cnt;
        wb_cycles(30);
        chk_range("wbrst_at_most_one", out_cnt[0] - snap[0], 0, 1);
        chk_eq("wbrst_quiet_after", out_cnt[0] - snap2[0], 0);
        rx_lf = 1'b0;
        snap = out_cnt;
        rx_pulse(0);
        wb_cycles(30);
        chk_eq("wbrst_realigned", out_cnt[0] - snap[0], 1);

        // RX reset right after delivery, while the ack is still returning
        snap = out_cnt;
        rx_pulse(0);
        wait_pulse(0, 20, n);
        chk_range("rxrst_delivered", n, 1, 20);
        reset_xgmii_rx_n = 1'b0;
        rx_tick(5);
        reset_xgmii_rx_n = 1'b1;
        wb_cycles(2 * SYNC_STAGES + 2);
        snap2 = out_cnt;
        wb_cycles(30);
        chk_range("rxrst_at_most_one_extra", out_cnt[0] - snap[0], 1, 2);
        chk_eq("rxrst_quiet_after", out_cnt[0] - snap2[0], 0);
        snap = out_cnt;
        rx_pulse(0);
        wb_cycles(30);
        chk_eq("rxrst_realigned", out_cnt[0] - snap[0], 1);

        // Random RX events with wb at 50 MHz against the scoreboard
        wb_half = 10.0;
        wb_cycles(20);
        snap = out_cnt;
        model_en = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk_xgmii_rx); #0.5;
            for (int b = 0; b < 4; b++) rx_in[b] = ($urandom_range(0, 9) == 0);
        end
        @(posedge clk_xgmii_rx); #0.5; rx_in = '0;
        wb_cycles(60);
        model_en = 1'b0;
        for (int b = 0; b < 4; b++) begin
            ref_in = in_cnt[b];
            chk_range($sformatf("rand_out_le_in[%0d]", b), out_cnt[b] - snap[b], 1, ref_in);
            chk_range($sformatf("rand_coalesced[%0d]", b), out_cnt[b] - snap[b], 1, ref_in - 1);
            chk_eq($sformatf("rand_no_lost_event[%0d]", b), late_cnt[b], 0);
            chk_range($sformatf("rand_min_spacing[%0d]", b), min_gap[b], SYNC_STAGES + 1, 1000000);
        end
        chk_eq("rand_tx_quiet", out_cnt[4] + out_cnt[5] + out_cnt[6] - snap[4] - snap[5] - snap[6], 0);
        chk_eq("pulse_width_one", wide_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
